// File: rtl/trace_bram_writer_if.sv
// -----------------------------------------------------------------------------
// trace_bram_writer_if
// Bundles the trace-word stream and the BRAM port-A write bus of the trace
// buffer capture engine.
//   s_tdata / s_tkeep / s_tvalid : trace word from the monitor
//   s_tready                     : accept, driven by the writer
//   bram_addr / bram_din /
//   bram_we / bram_en            : port-A write, driven by the writer
// master : the side that produces trace words and observes the BRAM bus
// slave  : the writer itself
// -----------------------------------------------------------------------------
interface trace_bram_writer_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 6
) ();
  localparam int NUM_BYTES = C_DATA_WIDTH / 8;

  logic [C_DATA_WIDTH-1:0] s_tdata;
  logic [NUM_BYTES-1:0]    s_tkeep;
  logic                    s_tvalid;
  logic                    s_tready;

  logic [C_ADDR_WIDTH-1:0] bram_addr;
  logic [C_DATA_WIDTH-1:0] bram_din;
  logic [NUM_BYTES-1:0]    bram_we;
  logic                    bram_en;

  modport master (
    output s_tdata, s_tkeep, s_tvalid,
    input  s_tready,
    input  bram_addr, bram_din, bram_we, bram_en
  );

  modport slave (
    input  s_tdata, s_tkeep, s_tvalid,
    output s_tready,
    output bram_addr, bram_din, bram_we, bram_en
  );
endinterface

// File: rtl/trace_bram_writer.sv
// -----------------------------------------------------------------------------
// trace_bram_writer
// Capture-side write engine of the trace buffer. Accepted trace words are
// written to consecutive word slots of the trace BRAM (port A), either until
// the buffer is full (C_WRAP=0) or circularly (C_WRAP=1). The stream is never
// back-pressured once out of reset; surplus words are dropped and flagged.
// Ports:
//   aclk, aresetn        : clock, asynchronous active-low reset
//   arm / stop / clear   : single-cycle control pulses
//   bus (slave)          : trace stream in, BRAM port-A write out
//   capturing            : state is ARMED
//   word_count / full    : valid words in the buffer (saturating)
//   wrapped / overflow   : sticky overwrite / drop flags
// -----------------------------------------------------------------------------
module trace_bram_writer #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_DATA_DEPTH = 16,
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_WRAP       = 0,
  localparam int CW          = $clog2(C_DATA_DEPTH) + 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 arm,
  input  logic                 stop,
  input  logic                 clear,
  trace_bram_writer_if.slave   bus,
  output logic                 capturing,
  output logic [CW-1:0]        word_count,
  output logic                 full,
  output logic                 wrapped,
  output logic                 overflow
);

  localparam int NUM_BYTES = C_DATA_WIDTH / 8;
  localparam int ADDR_LSB  = $clog2(NUM_BYTES);
  localparam int PW        = $clog2(C_DATA_DEPTH);
  localparam bit WRAP_EN   = (C_WRAP != 0);

  localparam logic [PW-1:0] LAST_PTR  = PW'(C_DATA_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(C_DATA_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PW-1:0]           r_ptr;
  logic [PW-1:0]           w_ptr_nxt;
  logic [CW-1:0]           r_count;
  logic [CW-1:0]           w_count_nxt;
  logic                    r_full;
  logic                    w_full_nxt;
  logic                    r_wrapped;
  logic                    w_wrapped_nxt;
  logic                    r_overflow;
  logic                    w_overflow_nxt;
  logic                    r_ready;
  logic                    r_capturing;
  logic                    w_beat;
  logic                    w_write;

  logic [C_ADDR_WIDTH-1:0] r_bram_addr;
  logic [C_DATA_WIDTH-1:0] r_bram_din;
  logic [NUM_BYTES-1:0]    r_bram_we;
  logic                    r_bram_en;

  assign w_beat = bus.s_tvalid & r_ready;

  // Next-state, pointer, count and flag logic; clear overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_count_nxt    = r_count;
    w_wrapped_nxt  = r_wrapped;
    w_overflow_nxt = r_overflow;
    w_write        = 1'b0;

    if (clear) begin
      w_state_nxt    = ST_IDLE;
      w_ptr_nxt      = '0;
      w_count_nxt    = '0;
      w_wrapped_nxt  = 1'b0;
      w_overflow_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Beats here are consumed but dropped; stop has no meaning yet.
          if (arm) begin
            w_state_nxt = ST_ARMED;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end

        ST_ARMED: begin
          if (w_beat) begin
            if (!WRAP_EN && r_full) begin
              // Re-armed on a full stop-mode buffer: nothing left to write.
              w_overflow_nxt = 1'b1;
              w_state_nxt    = ST_DONE;
            end else begin
              w_write = 1'b1;
              // Count saturates; a write on a full circular buffer overwrites.
              if (r_count == DEPTH_CNT) begin
                w_wrapped_nxt = 1'b1;
              end else begin
                w_count_nxt = r_count + CW'(1);
              end
              if (r_ptr == LAST_PTR) begin
                if (WRAP_EN) begin
                  w_ptr_nxt = '0;
                end else begin
                  w_state_nxt = ST_DONE;
                end
              end else begin
                w_ptr_nxt = r_ptr + PW'(1);
              end
            end
          end else begin
            w_write = 1'b0;
          end
          // A filled buffer lands in DONE even when stop arrives with the
          // last beat; otherwise stop returns to IDLE after the write.
          if (stop && (w_state_nxt == ST_ARMED)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = w_state_nxt;
          end
        end

        ST_DONE: begin
          if (w_beat) begin
            w_overflow_nxt = 1'b1;
          end else begin
            w_overflow_nxt = r_overflow;
          end
          if (stop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    w_full_nxt = (w_count_nxt == DEPTH_CNT);
  end

  // Control state and status registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_wrapped   <= 1'b0;
      r_overflow  <= 1'b0;
      r_ready     <= 1'b0;
      r_capturing <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_count     <= w_count_nxt;
      r_full      <= w_full_nxt;
      r_wrapped   <= w_wrapped_nxt;
      r_overflow  <= w_overflow_nxt;
      r_ready     <= 1'b1;
      r_capturing <= (w_state_nxt == ST_ARMED);
    end
  end

  // BRAM port-A write registers; address and data hold between writes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_bram_we   <= '0;
      r_bram_en   <= 1'b0;
    end else begin
      r_bram_en <= w_write;
      if (w_write) begin
        r_bram_addr <= C_ADDR_WIDTH'(r_ptr) << ADDR_LSB;
        r_bram_din  <= bus.s_tdata;
        r_bram_we   <= bus.s_tkeep;
      end else begin
        r_bram_we   <= '0;
      end
    end
  end

  assign bus.s_tready  = r_ready;
  assign bus.bram_addr = r_bram_addr;
  assign bus.bram_din  = r_bram_din;
  assign bus.bram_we   = r_bram_we;
  assign bus.bram_en   = r_bram_en;

  assign capturing  = r_capturing;
  assign word_count = r_count;
  assign full       = r_full;
  assign wrapped    = r_wrapped;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_trace_bram_writer.sv
// Bench for trace_bram_writer: one stop-mode and one circular instance share
// all stimulus. A word-count-based reference model checks both every cycle.
module tb_trace_bram_writer;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 6;
  localparam int NB    = 4;
  localparam int CW    = 5;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DONE  = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic arm = 1'b0, stop = 1'b0, clear = 1'b0;
  logic cap0, cap1, full0, full1, wrap0, wrap1, ovf0, ovf1;
  logic [CW-1:0] cnt0, cnt1;

  always #5 aclk = ~aclk;

  trace_bram_writer_if #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW)) if0 ();
  trace_bram_writer_if #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW)) if1 ();

  trace_bram_writer #(.C_DATA_WIDTH(DW), .C_DATA_DEPTH(DEPTH), .C_ADDR_WIDTH(AW), .C_WRAP(0)) u_dut0 (
    .aclk(aclk), .aresetn(aresetn), .arm(arm), .stop(stop), .clear(clear), .bus(if0),
    .capturing(cap0), .word_count(cnt0), .full(full0), .wrapped(wrap0), .overflow(ovf0));

  trace_bram_writer #(.C_DATA_WIDTH(DW), .C_DATA_DEPTH(DEPTH), .C_ADDR_WIDTH(AW), .C_WRAP(1)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn), .arm(arm), .stop(stop), .clear(clear), .bus(if1),
    .capturing(cap1), .word_count(cnt1), .full(full1), .wrapped(wrap1), .overflow(ovf1));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words written since clear, per instance
  int            m_state [2];
  int            m_n     [2];
  logic          m_ovf   [2];
  logic          m_ready;
  logic          e_en    [2];
  logic [AW-1:0] e_addr  [2];
  logic [NB-1:0] e_we    [2];
  logic [DW-1:0] e_din   [2];

  typedef struct {
    logic a, s, c, v;
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          en;
    logic [AW-1:0] addr;
    logic [NB-1:0] we;
    logic [CW-1:0] cnt;
    logic          cap;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input int cfg, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (wrap=%0d): got 0x%0h expected 0x%0h at %0t", name, cfg, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_state[c] = M_IDLE; m_n[c] = 0; m_ovf[c] = 1'b0;
      e_en[c] = 1'b0; e_we[c] = '0; e_addr[c] = '0; e_din[c] = '0;
    end
  endtask

  task automatic model_step(input logic a, input logic s, input logic c, input logic v,
                            input logic [DW-1:0] d, input logic [NB-1:0] k);
    for (int i = 0; i < 2; i++) begin
      bit wrap_mode = (i == 1);
      bit beat = v && m_ready;
      e_en[i] = 1'b0;
      e_we[i] = '0;
      if (c) begin
        m_state[i] = M_IDLE; m_n[i] = 0; m_ovf[i] = 1'b0;
      end else if (m_state[i] == M_IDLE) begin
        if (a) m_state[i] = M_ARMED;
      end else if (m_state[i] == M_ARMED) begin
        if (beat) begin
          if (!wrap_mode && m_n[i] >= DEPTH) begin
            m_ovf[i] = 1'b1;
            m_state[i] = M_DONE;
          end else begin
            e_en[i]   = 1'b1;
            e_we[i]   = k;
            e_din[i]  = d;
            e_addr[i] = AW'((m_n[i] % DEPTH) * NB);
            m_n[i]++;
            if (!wrap_mode && m_n[i] == DEPTH) m_state[i] = M_DONE;
          end
        end
        if (s && m_state[i] == M_ARMED) m_state[i] = M_IDLE;
      end else begin
        if (beat) m_ovf[i] = 1'b1;
        if (s) m_state[i] = M_IDLE;
      end
    end
    m_ready = 1'b1;
  endtask

  task automatic check_model();
    for (int c = 0; c < 2; c++) begin
      logic rdy, en, fl, wr, ov, cp;
      logic [NB-1:0] we;
      logic [AW-1:0] ad;
      logic [DW-1:0] dn;
      logic [CW-1:0] cn;
      int ecnt;
      if (c == 0) begin
        rdy = if0.s_tready; en = if0.bram_en; we = if0.bram_we; ad = if0.bram_addr; dn = if0.bram_din;
        cn = cnt0; fl = full0; wr = wrap0; ov = ovf0; cp = cap0;
      end else begin
        rdy = if1.s_tready; en = if1.bram_en; we = if1.bram_we; ad = if1.bram_addr; dn = if1.bram_din;
        cn = cnt1; fl = full1; wr = wrap1; ov = ovf1; cp = cap1;
      end
      ecnt = (m_n[c] > DEPTH) ? DEPTH : m_n[c];
      chk("s_tready", c, rdy, m_ready);
      chk("bram_en", c, en, e_en[c]);
      chk("bram_we", c, we, e_we[c]);
      if (e_en[c]) begin
        chk("bram_addr", c, ad, e_addr[c]);
        chk("bram_din", c, dn, e_din[c]);
      end
      chk("word_count", c, cn, ecnt);
      chk("full", c, fl, m_n[c] >= DEPTH);
      chk("wrapped", c, wr, (c == 1) && (m_n[c] > DEPTH));
      chk("overflow", c, ov, m_ovf[c]);
      chk("capturing", c, cp, m_state[c] == M_ARMED);
    end
  endtask

  task automatic step(input logic a, input logic s, input logic c, input logic v,
                      input logic [DW-1:0] d, input logic [NB-1:0] k);
    @(negedge aclk);
    arm = a; stop = s; clear = c;
    if0.s_tvalid = v; if0.s_tdata = d; if0.s_tkeep = k;
    if1.s_tvalid = v; if1.s_tdata = d; if1.s_tkeep = k;
    @(posedge aclk);
    model_step(a, s, c, v, d, k);
    #1;
    check_model();
  endtask

  task automatic idle(); step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0); endtask
  task automatic beat(input logic [DW-1:0] d); step(1'b0, 1'b0, 1'b0, 1'b1, d, 4'hF); endtask

  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic async_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      chk("rst_tready", c, (c == 0) ? if0.s_tready : if1.s_tready, 1'b0);
      chk("rst_en",     c, (c == 0) ? if0.bram_en  : if1.bram_en, 1'b0);
      chk("rst_we",     c, (c == 0) ? if0.bram_we  : if1.bram_we, 4'h0);
      chk("rst_addr",   c, (c == 0) ? if0.bram_addr : if1.bram_addr, 6'h0);
      chk("rst_din",    c, (c == 0) ? if0.bram_din : if1.bram_din, 32'h0);
      chk("rst_count",  c, (c == 0) ? cnt0 : cnt1, 5'h0);
      chk("rst_flags",  c, (c == 0) ? {full0, wrap0, ovf0, cap0} : {full1, wrap1, ovf1, cap1}, 4'h0);
    end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  function automatic vec_t mk(input logic a, input logic s, input logic c, input logic v,
                              input logic [DW-1:0] d, input logic [NB-1:0] k, input logic en,
                              input logic [AW-1:0] addr, input logic [NB-1:0] we,
                              input logic [CW-1:0] cnt, input logic cap);
    vec_t t;
    t.a = a; t.s = s; t.c = c; t.v = v; t.d = d; t.k = k;
    t.en = en; t.addr = addr; t.we = we; t.cnt = cnt; t.cap = cap;
    return t;
  endfunction

  initial begin
    int wr_cnt;
    logic [AW-1:0] last_addr;

    if0.s_tvalid = 1'b0; if0.s_tdata = '0; if0.s_tkeep = '0;
    if1.s_tvalid = 1'b0; if1.s_tdata = '0; if1.s_tkeep = '0;
    model_reset();
    repeat (2) @(negedge aclk);
    async_reset();
    repeat (2) idle();

    //            a     s     c     v     data        keep  en    addr   we    cnt    cap
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'hEE, 4'hF, 1'b0, 6'd0,  4'h0, 5'd0, 1'b1);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 4'hF, 1'b1, 6'd0,  4'hF, 5'd1, 1'b1);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hA1, 4'hF, 1'b1, 6'd4,  4'hF, 5'd2, 1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hA2, 4'hF, 1'b1, 6'd8,  4'hF, 5'd3, 1'b1);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hA3, 4'hF, 1'b1, 6'd12, 4'hF, 5'd4, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hA4, 4'hF, 1'b1, 6'd16, 4'hF, 5'd5, 1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 1'b0, 6'd0,  4'h0, 5'd5, 1'b1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 32'hA5, 4'h5, 1'b1, 6'd20, 4'h5, 5'd6, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hB0, 4'hF, 1'b0, 6'd0,  4'h0, 5'd6, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 1'b0, 6'd0,  4'h0, 5'd6, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hC0, 4'h0, 1'b1, 6'd24, 4'h0, 5'd7, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'hC1, 4'hF, 1'b0, 6'd0,  4'h0, 5'd0, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 1'b0, 6'd0,  4'h0, 5'd0, 1'b1);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hD0, 4'hF, 1'b1, 6'd0,  4'hF, 5'd1, 1'b1);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hD1, 4'hF, 1'b1, 6'd4,  4'hF, 5'd2, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hD2, 4'hF, 1'b1, 6'd8,  4'hF, 5'd3, 1'b1);
    tbl[16] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 4'h0, 1'b0, 6'd0,  4'h0, 5'd3, 1'b0);
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 1'b0, 6'd0,  4'h0, 5'd3, 1'b1);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hD3, 4'hF, 1'b1, 6'd12, 4'hF, 5'd4, 1'b1);
    tbl[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 4'h0, 1'b0, 6'd0,  4'h0, 5'd0, 1'b0);

    // Table: basic capture, byte enables and control collisions (stop-mode instance)
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].a, tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].k);
      chk($sformatf("tbl%0d_en", i), 0, if0.bram_en, tbl[i].en);
      chk($sformatf("tbl%0d_we", i), 0, if0.bram_we, tbl[i].we);
      chk($sformatf("tbl%0d_cnt", i), 0, cnt0, tbl[i].cnt);
      chk($sformatf("tbl%0d_cap", i), 0, cap0, tbl[i].cap);
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d_addr", i), 0, if0.bram_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_din", i), 0, if0.bram_din, tbl[i].d);
      end
    end

    // Fill and overflow: 18 back-to-back beats
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    wr_cnt = 0;
    last_addr = '0;
    for (int i = 0; i < 18; i++) begin
      beat(32'h100 + 32'(i));
      if (if0.bram_en) begin
        wr_cnt++;
        last_addr = if0.bram_addr;
      end
      if (i == 15) begin
        chk("fill_full_at_16", 0, full0, 1'b1);
        chk("fill_cnt_at_16", 0, cnt0, 5'd16);
      end
    end
    idle();
    chk("fill_writes", 0, wr_cnt, 16);
    chk("fill_last_addr", 0, last_addr, 6'd60);
    chk("fill_overflow", 0, ovf0, 1'b1);
    chk("fill_done_not_capturing", 0, cap0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    chk("clear_flags", 0, {full0, wrap0, ovf0, cap0}, 4'h0);
    chk("clear_cnt", 0, cnt0, 5'd0);
    chk("clear_wrapped", 1, wrap1, 1'b0);

    // Wrap: 20 beats on the circular instance
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      beat(32'(i));
      if (i >= 16) begin
        chk($sformatf("wrap_en_beat%0d", i), 1, if1.bram_en, 1'b1);
        chk($sformatf("wrap_addr_beat%0d", i), 1, if1.bram_addr, 6'((i - 16) * 4));
      end
    end
    chk("wrap_cnt", 1, cnt1, 5'd16);
    chk("wrap_flag", 1, wrap1, 1'b1);
    chk("wrap_ovf", 1, ovf1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);

    // Reset mid-stream, then a fresh capture starts at address 0
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) beat(32'h200 + 32'(i));
    async_reset();
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    beat(32'h300);
    chk("post_reset_en", 0, if0.bram_en, 1'b1);
    chk("post_reset_addr", 0, if0.bram_addr, 6'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(7) == 0), ($urandom_range(9) == 0), ($urandom_range(39) == 0),
           ($urandom_range(3) != 0), $urandom, 4'($urandom_range(15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_bram_writer.md
# trace_bram_writer

Capture-side write engine for the trace buffer. Accepts a stream of trace words from the monitor/adapter logic and writes them into consecutive word slots of the dual-port byte-enabled trace BRAM through its port A, with a word count and status flags for the readout path. Runs in either stop-when-full or circular (wrap) mode. Never back-pressures the monitor once out of reset; excess words are dropped and flagged.

## Interface
- C_DATA_WIDTH, 32, trace word width; multiple of 8.
- C_DATA_DEPTH, 16, number of words in the BRAM; power of two, ≥2.
- C_ADDR_WIDTH, 6, BRAM byte-address width; equals log2(C_DATA_DEPTH) + log2(C_DATA_WIDTH/8).
- C_WRAP, 0, 0 = stop when full, 1 = circular overwrite.

Derived values:
- NUM_BYTES = C_DATA_WIDTH/8.
- ADDR_LSB = log2(NUM_BYTES).
- CW = log2(C_DATA_DEPTH)+1.

Ports:
- aclk  in  1  single clock for the block.
- aresetn  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse that starts capture.
- stop  in  1  single-cycle pulse that ends capture.
- clear  in  1  single-cycle pulse: synchronous flush of pointer, count and flags.
- s_tdata  in  C_DATA_WIDTH  trace word.
- s_tkeep  in  NUM_BYTES  byte enables for the word.
- s_tvalid  in  1  word valid.
- s_tready  out  1  accept.
- bram_addr  out  C_ADDR_WIDTH  byte address to BRAM port A; the low ADDR_LSB bits are always 0.
- bram_din  out  C_DATA_WIDTH  write data.
- bram_we  out  NUM_BYTES  per-byte write enable.
- bram_en  out  1  port enable.
- capturing  out  1  high in state ARMED.
- word_count  out  CW  number of valid words in the buffer; saturates at C_DATA_DEPTH.
- full  out  1  word_count == C_DATA_DEPTH.
- wrapped  out  1  sticky: at least one word has been overwritten (C_WRAP=1 only).
- overflow  out  1  sticky: at least one word was dropped in DONE (C_WRAP=0 only).

## Operation
- The FSM has three states: IDLE, ARMED, DONE. Reset state is IDLE.
- IDLE:
  - arm → ARMED. stop is ignored.
  - Accepted beats are discarded and the BRAM is not written.
- ARMED:
  - Each accepted beat (s_tvalid & s_tready) is written to word slot ptr.
  - ptr advances by 1 per beat.
  - word_count increments by 1 per beat, saturating at C_DATA_DEPTH.
  - A beat with s_tkeep = 0 still consumes a slot.
  - stop → IDLE; ptr and count are preserved, so a later arm appends.
  - arm is ignored.
- Write to the last slot (ptr = C_DATA_DEPTH-1):
  - C_WRAP=0: ptr stays, full=1, next state DONE.
  - C_WRAP=1: ptr → 0, state stays ARMED. Every later beat sets wrapped=1. word_count stays at C_DATA_DEPTH.
- DONE:
  - Accepted beats are discarded and set overflow=1.
  - stop → IDLE.
  - arm is ignored; clear is required to reuse the buffer.
- clear has priority over every other input. It forces state IDLE, ptr 0, word_count 0, and clears full, wrapped and overflow. A beat in the same cycle as clear is discarded.
- A beat in the same cycle as stop (in ARMED) is written; stop takes effect afterwards.
- A beat in the same cycle as arm (in IDLE) is discarded.
- When both arm and stop are asserted, only the input that is valid for the current state acts.
- bram_din = s_tdata and bram_we = s_tkeep of the written beat.
- bram_addr = ptr << ADDR_LSB.

## Timing
- s_tready = 0 while aresetn is low. It is 1 from the first aclk edge after deassertion and then stays 1; it is a registered output.
- Write latency: a beat accepted at edge N drives bram_en=1, bram_we, bram_din and bram_addr for the cycle following edge N. These outputs are registered.
  - bram_we = 0 and bram_en = 0 in every cycle with no write.
  - Back-to-back beats produce one write per cycle to consecutive addresses.
- Status updates at the same edge as the corresponding BRAM write:
  - word_count and full update at the write edge.
  - wrapped and overflow set at the edge after the offending beat.
- capturing follows the state register: it changes at the edge that samples arm, stop or clear.
- Reset values:
  - All outputs are 0, including bram_addr, bram_din, bram_we, bram_en, word_count, the flags and capturing.
  - Internal state: state IDLE, ptr 0.
- Asserting reset mid-capture aborts immediately. A write issued before reset is not guaranteed.

## Test plan
- **Basic capture** (C_WRAP=0, depth 16, width 32): arm, then 5 beats 0xA0..0xA4 with tkeep=0xF.
  - Required: 5 writes at byte addresses 0, 4, 8, 12, 16 with we=0xF, each one cycle after its beat.
  - Required: word_count=5, full=0.
- **Fill and overflow**: arm, 18 back-to-back beats.
  - Required: 16 writes, with the last at address 60; full=1 at the 16th write; state DONE.
  - Required: beats 17 and 18 are not written; overflow=1.
  - Then clear → all flags 0, word_count 0.
- **Wrap** (C_WRAP=1): arm, 20 beats 0..19.
  - Required: beats 16..19 are written at addresses 0, 4, 8, 12.
  - Required: word_count=16, wrapped=1, overflow=0.
- **Control collisions**:
  - Beat together with stop in ARMED → written, then capturing=0.
  - Beat together with arm in IDLE → not written.
  - clear together with a beat in ARMED → no write, count 0.
  - Second arm after stop with count 3 → the next write goes to address 12.
- **Byte enables and reset**:
  - A beat with tkeep=0x5 gives bram_we=0x5.
  - A beat with tkeep=0 gives no write strobes but word_count still increments.
  - aresetn pulsed low mid-stream → all outputs 0, state IDLE.
  - The next arm starts writing at address 0.
